// File: rtl/pong_game_ctrl_if.sv
// Datapath-facing signal bundle for the Pong game controller.
// The master side owns video counters, buttons and ball events; the slave is the controller.
interface pong_game_ctrl_if;
  logic [11:0] CounterX;
  logic [11:0] CounterY;
  logic        btn_left;
  logic        btn_right;
  logic        btn_start;
  logic        paddle_hit;
  logic        ball_lost;
  logic [11:0] PaddlePosition;
  logic        ball_enable;
  logic        ball_serve;
  logic [2:0]  lives;
  logic [7:0]  score;
  logic [2:0]  state;

  modport master (
    output CounterX, CounterY, btn_left, btn_right, btn_start, paddle_hit, ball_lost,
    input  PaddlePosition, ball_enable, ball_serve, lives, score, state
  );

  modport slave (
    input  CounterX, CounterY, btn_left, btn_right, btn_start, paddle_hit, ball_lost,
    output PaddlePosition, ball_enable, ball_serve, lives, score, state
  );
endinterface

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: paddle position, game FSM, lives and score, all advanced once per frame
// so the drawing logic sees stable values throughout the active area.
module pong_game_ctrl #(
  parameter int hDrawArea   = 640,
  parameter int vDrawArea   = 480,
  parameter int PaddleWidth = 112,
  parameter int PaddleSpeed = 4,
  parameter int ServeFrames = 60,
  parameter int LostFrames  = 90,
  parameter int StartLives  = 3
) (
  input  logic             clk,
  input  logic             reset,
  pong_game_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    LOST  = 3'd3,
    OVER  = 3'd4
  } gameState_t;

  localparam logic [11:0] PaddleHome = 12'((hDrawArea - PaddleWidth) / 2 - 8);
  localparam logic [11:0] PaddleMax  = 12'(hDrawArea - PaddleWidth - 16);
  localparam logic [11:0] PaddleStep = 12'(PaddleSpeed);
  localparam logic [7:0]  ServeLast  = 8'(ServeFrames - 1);
  localparam logic [7:0]  LostLast   = 8'(LostFrames - 1);
  localparam logic [2:0]  LivesInit  = 3'(StartLives);

  logic [1:0]  leftSync, rightSync, startSync;
  logic        startDly;
  logic        startFlag, hitFlag, lostFlag;
  logic        frameTick, startRise;

  gameState_t  state;
  logic [7:0]  frameCnt;
  logic [2:0]  lives;
  logic [7:0]  score;
  logic [11:0] paddlePos;
  logic [11:0] paddleNext;
  logic [12:0] padUp;
  logic        ballEnable, ballServe;

  // One clock per frame: first pixel of the first blanking line.
  assign frameTick = (bus.CounterX == 12'd0) && (bus.CounterY == 12'(vDrawArea));
  assign startRise = startSync[1] & ~startDly;

  // Button synchronisers and the per-frame event flags. A pulse landing on the tick cycle
  // itself is captured for the following frame rather than lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      leftSync  <= 2'b00;
      rightSync <= 2'b00;
      startSync <= 2'b00;
      startDly  <= 1'b0;
      startFlag <= 1'b0;
      hitFlag   <= 1'b0;
      lostFlag  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so each flop stage samples the pre-edge value of the one before.
      leftSync  <= {leftSync[0],  bus.btn_left};
      rightSync <= {rightSync[0], bus.btn_right};
      startSync <= {startSync[0], bus.btn_start};
      startDly  <= startSync[1];
      if (frameTick) begin
        startFlag <= startRise;
        hitFlag   <= bus.paddle_hit;
        lostFlag  <= bus.ball_lost;
      end else begin
        startFlag <= startFlag | startRise;
        hitFlag   <= hitFlag   | bus.paddle_hit;
        lostFlag  <= lostFlag  | bus.ball_lost;
      end
    end
  end

  // Candidate paddle position for this frame; widened by one bit so the clamps cannot wrap.
  always_comb begin
    // NOTE: defaults first so every path assigns both signals and no latch is inferred.
    padUp      = {1'b0, paddlePos} + {1'b0, PaddleStep};
    paddleNext = paddlePos;
    if (leftSync[1] && !rightSync[1]) begin
      paddleNext = ({1'b0, paddlePos} >= {1'b0, PaddleStep}) ? paddlePos - PaddleStep : 12'd0;
    end else if (rightSync[1] && !leftSync[1]) begin
      paddleNext = (padUp > {1'b0, PaddleMax}) ? PaddleMax : padUp[11:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      frameCnt   <= 8'd0;
      lives      <= 3'd0;
      score      <= 8'd0;
      paddlePos  <= PaddleHome;
      ballEnable <= 1'b0;
      ballServe  <= 1'b0;
    end else begin
      // NOTE: the later assignment to ballServe in this block wins, giving a one-clock pulse.
      ballServe <= 1'b0;
      if (frameTick) begin
        frameCnt <= frameCnt + 8'd1;
        if (state == SERVE || state == PLAY) begin
          paddlePos <= paddleNext;
        end
        unique case (state)
          IDLE: begin
            if (startFlag) begin
              state     <= SERVE;
              frameCnt  <= 8'd0;
              lives     <= LivesInit;
              score     <= 8'd0;
              ballServe <= 1'b1;
            end
          end
          SERVE: begin
            if (frameCnt == ServeLast) begin
              state      <= PLAY;
              frameCnt   <= 8'd0;
              ballEnable <= 1'b1;
            end
          end
          PLAY: begin
            // A hit and a loss in the same frame both take effect: score first, then LOST.
            if (hitFlag && score != 8'hFF) begin
              score <= score + 8'd1;
            end
            if (lostFlag) begin
              state      <= LOST;
              frameCnt   <= 8'd0;
              ballEnable <= 1'b0;
              if (lives != 3'd0) begin
                lives <= lives - 3'd1;
              end
            end
          end
          LOST: begin
            if (frameCnt == LostLast) begin
              frameCnt <= 8'd0;
              if (lives == 3'd0) begin
                state <= OVER;
              end else begin
                state     <= SERVE;
                ballServe <= 1'b1;
              end
            end
          end
          OVER: begin
            if (startFlag) begin
              state    <= IDLE;
              frameCnt <= 8'd0;
            end
          end
          default: begin
            state      <= IDLE;
            frameCnt   <= 8'd0;
            ballEnable <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.PaddlePosition = paddlePos;
  assign bus.ball_enable    = ballEnable;
  assign bus.ball_serve     = ballServe;
  assign bus.lives          = lives;
  assign bus.score          = score;
  assign bus.state          = state;

endmodule

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
Game-sequencing controller for the Pong video datapath. Owns the paddle position, the game-state FSM (idle, serve, play, point-lost, game-over), lives and score. It gates ball motion and requests ball re-serve. All state updates occur on the per-frame tick derived from the video counters, so the drawing logic always sees stable values during the active area.

Parameters:
hDrawArea, 640, active horizontal pixels
vDrawArea, 480, active vertical lines
PaddleWidth, 112, paddle width in pixels; sets the right clamp
PaddleSpeed, 4, pixels moved per frame while a button is held
ServeFrames, 60, frames spent in SERVE before PLAY
LostFrames, 90, frames spent in LOST before the next SERVE or OVER
StartLives, 3, lives loaded at game start (1..7)

Ports:
clk  in  1  system/pixel clock
reset  in  1  synchronous, active-high reset
CounterX  in  12  current pixel column from the video timing block
CounterY  in  12  current line from the video timing block
btn_left  in  1  asynchronous button, active-high
btn_right  in  1  asynchronous button, active-high
btn_start  in  1  asynchronous button, active-high
paddle_hit  in  1  one-clk pulse from the datapath: ball bounced off the paddle
ball_lost  in  1  one-clk pulse from the datapath: ball passed below the paddle
PaddlePosition  out  12  paddle left coordinate offset, registered
ball_enable  out  1  1 allows the ball to move; 0 freezes it
ball_serve  out  1  one-clk pulse: reload the ball to its serve position
lives  out  3  remaining lives
score  out  8  paddle hits this game, saturating
state  out  3  FSM state encoding for overlay/debug

Behaviour:
- Clock is clk. Reset is synchronous and active-high. Reset values:
  - PaddlePosition = (hDrawArea-PaddleWidth)/2 - 8, which is 256 with defaults.
  - ball_enable = 0, ball_serve = 0, lives = 0, score = 0, state = IDLE.
- Buttons pass through a 2-flop synchroniser (reset to 0). start_rise is the rising edge of the synchronised btn_start, held in a sticky flag until the next FrameTick consumes it.
- FrameTick = (CounterX==0) && (CounterY==vDrawArea), one clock per frame. All FSM, paddle, frame-counter and lives updates occur only on FrameTick.
- paddle_hit and ball_lost are latched into sticky flags. The flags are consumed and cleared on FrameTick. A new pulse arriving in the same cycle as FrameTick is kept for the next frame.
- States and encoding: IDLE=0, SERVE=1, PLAY=2, LOST=3, OVER=4.
  - IDLE: start -> SERVE. On this transition load lives=StartLives, clear score, pulse ball_serve.
  - SERVE: count frames. After ServeFrames ticks -> PLAY.
  - PLAY: ball_enable=1. A ball_lost flag -> LOST, and lives decrements by 1 in the same tick.
  - LOST: count LostFrames ticks. If lives==0 -> OVER. Otherwise -> SERVE, pulsing ball_serve.
  - OVER: start -> IDLE. Score and lives hold their values until then.
- ball_enable is 1 only in PLAY. It is registered and updates in the cycle after the FrameTick that changes state.
- ball_serve is high for exactly one clock: the cycle after the FrameTick that enters SERVE.
- The frame counter is 8 bits and clears on every state entry.
- Score:
  - +1 per consumed paddle_hit flag, only while in PLAY.
  - Saturates at 255 with no wrap.
  - If paddle_hit and ball_lost are both pending on the same tick: score increments, then the state goes to LOST.
- Paddle:
  - Moves only in SERVE and PLAY.
  - left only: position -= PaddleSpeed, clamped at 0 with no underflow wrap.
  - right only: position += PaddleSpeed, clamped at hDrawArea-PaddleWidth-16.
  - Both buttons or neither: hold.
  - Comparisons are done at 13 bits to avoid wrap.
- Reset asserted mid-game overrides everything in that cycle. start held through reset does not trigger a start, because the synchroniser history is cleared.

Test Plan:
1. Reset, then a start pulse -> next FrameTick: state=1, lives=3, score=0, one-clock ball_serve. After 60 ticks: state=2, ball_enable=1.
2. In PLAY, hold btn_left for 70 frames from 256 -> PaddlePosition reaches 0 after 64 frames and stays 0. Hold btn_right for 200 frames -> clamps at 512.
3. Three paddle_hit pulses between ticks -> score +1 per consumed frame. A pulse coinciding with FrameTick is counted on the following tick. Force score to 255, then hit -> score stays 255.
4. ball_lost in PLAY with lives=3 -> state=3, lives=2, ball_enable=0 after the tick. After 90 ticks: state=1 with a ball_serve pulse.
5. Lose all three lives -> after the last LOST period state=4, and score is retained. Start -> state=0. Start again -> lives=3, score=0.
6. paddle_hit and ball_lost in the same frame -> score increments and state=3. Assert reset during PLAY -> all outputs at reset values the next cycle.
